regfile_wb_arbiter: RTL and testbench

//  Write-side master for the 8x16 register file write port (we/rd/wd).

---
 rtl/regfile_wb_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: ALU results first, buffered load returns with a starvation guard.
// Optional WB_BYPASS_EN: idle-cycle loads skip the FIFO and write one cycle after arrival.
module regfile_wb_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       alu_valid,
   output logic                       alu_ready,
   input  logic [2:0]                 alu_rd,
   input  logic [15:0]                alu_data,
   input  logic                       mem_valid,
   output logic                       mem_ready,
   input  logic [2:0]                 mem_rd,
   input  logic [15:0]                mem_data,
   output logic                       rf_we,
   output logic [2:0]                 rf_rd,
   output logic [15:0]                rf_wd,
   output logic [7:0]                 busy_mask,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [2:0]    fifo_rd   [DEPTH];
   logic [15:0]   fifo_data [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [SW-1:0] starve_cnt;

   logic fifo_nonempty;
   logic force_pop;
   logic pop;
   logic push;
   logic bypass;

   assign fifo_nonempty = (count != '0);
   assign force_pop     = (starve_cnt == SW'(STARVE_LIMIT)) && fifo_nonempty;
   assign pop           = force_pop || (!alu_valid && fifo_nonempty);
   assign alu_ready     = !force_pop;
   assign mem_ready     = (count < CW'(DEPTH));
   assign fifo_count    = count;

`ifdef WB_BYPASS_EN
   assign bypass = !fifo_nonempty && !alu_valid && mem_valid;
`else
   assign bypass = 1'b0;
`endif

   assign push = mem_valid && mem_ready && !bypass;

   // Mask is built from registered state only, so a popped entry drops out the cycle after its pop.
   always_comb begin
      busy_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < count) busy_mask[fifo_rd[rd_ptr + PW'(i)]] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         starve_cnt <= '0;
         rf_we      <= 1'b0;
         rf_rd      <= '0;
         rf_wd      <= '0;
      end else begin
         rf_we <= 1'b0;
         if (force_pop) begin
            rf_we      <= 1'b1;
            rf_rd      <= fifo_rd[rd_ptr];
            rf_wd      <= fifo_data[rd_ptr];
            starve_cnt <= '0;
         end else if (alu_valid) begin
            rf_we      <= 1'b1;
            rf_rd      <= alu_rd;
            rf_wd      <= alu_data;
            starve_cnt <= fifo_nonempty ? starve_cnt + SW'(1) : '0;
         end else if (fifo_nonempty) begin
            rf_we      <= 1'b1;
            rf_rd      <= fifo_rd[rd_ptr];
            rf_wd      <= fifo_data[rd_ptr];
            starve_cnt <= '0;
         end else if (bypass) begin
            rf_we <= 1'b1;
            rf_rd <= mem_rd;
            rf_wd <= mem_data;
         end

         if (push) begin
            fifo_rd[wr_ptr]   <= mem_rd;
            fifo_data[wr_ptr] <= mem_data;
            wr_ptr            <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);

         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; compile with and without WB_BYPASS_EN.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid;
   logic        alu_ready;
   logic [2:0]  alu_rd;
   logic [15:0] alu_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [2:0]  mem_rd;
   logic [15:0] mem_data;
   logic        rf_we;
   logic [2:0]  rf_rd;
   logic [15:0] rf_wd;
   logic [7:0]  busy_mask;
   logic [2:0]  fifo_count;

   int n_cmp = 0;
   int n_err = 0;

   regfile_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
      .busy_mask(busy_mask), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0; alu_rd = 3'd0; alu_data = 16'h0;
      mem_valid = 1'b0; mem_rd = 3'd0; mem_data = 16'h0;
   endtask

   task automatic test_reset();
      int writes;
      alu_valid = 1'b1; alu_rd = 3'd0; alu_data = 16'h00F0;
      mem_valid = 1'b1; mem_rd = 3'd1; mem_data = 16'h1111;
      tick();
      mem_rd = 3'd2; mem_data = 16'h2222;
      tick();
      idle_inputs();
      n_cmp++; if (fifo_count !== 3'd2) begin n_err++; $display("FAIL rst_pre_count: got %0d want 2", fifo_count); end
      n_cmp++; if (busy_mask !== 8'h06) begin n_err++; $display("FAIL rst_pre_busy: got %h want 06", busy_mask); end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", rf_we); end
      n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
      n_cmp++; if (busy_mask !== 8'h00) begin n_err++; $display("FAIL rst_busy: got %h want 00", busy_mask); end
      n_cmp++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL rst_mem_ready: got %b want 1", mem_ready); end
      n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL rst_alu_ready: got %b want 1", alu_ready); end
      n_cmp++; if ({rf_rd, rf_wd} !== 19'h0) begin n_err++; $display("FAIL rst_rf_regs: got rd=%0d wd=%h want 0/0000", rf_rd, rf_wd); end
      writes = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (rf_we !== 1'b0) writes++;
      end
      n_cmp++; if (writes !== 0) begin n_err++; $display("FAIL rst_flushed_writes: got %0d writes want 0", writes); end
   endtask

   task automatic test_alu_path();
      alu_valid = 1'b1; alu_rd = 3'd3; alu_data = 16'h1234;
      tick();
      alu_valid = 1'b0;
      n_cmp++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL alu_we: got %b want 1", rf_we); end
      n_cmp++; if (rf_rd !== 3'd3) begin n_err++; $display("FAIL alu_rd: got %0d want 3", rf_rd); end
      n_cmp++; if (rf_wd !== 16'h1234) begin n_err++; $display("FAIL alu_wd: got %h want 1234", rf_wd); end
      tick();
      n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL alu_idle_we: got %b want 0", rf_we); end
      n_cmp++; if ({rf_rd, rf_wd} !== {3'd3, 16'h1234}) begin n_err++; $display("FAIL alu_idle_hold: got rd=%0d wd=%h want 3/1234", rf_rd, rf_wd); end
   endtask

   task automatic test_fill();
      logic [2:0] rds [4];
      rds[0] = 3'd1; rds[1] = 3'd2; rds[2] = 3'd5; rds[3] = 3'd6;
      alu_valid = 1'b1; alu_rd = 3'd0; alu_data = 16'h0A0A;
      for (int i = 0; i < 4; i++) begin
         mem_valid = 1'b1; mem_rd = rds[i]; mem_data = 16'h1000 + 16'(rds[i]);
         tick();
      end
      n_cmp++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL fill_count: got %0d want 4", fifo_count); end
      n_cmp++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL fill_mem_ready: got %b want 0", mem_ready); end
      n_cmp++; if (busy_mask !== 8'h66) begin n_err++; $display("FAIL fill_busy: got %h want 66", busy_mask); end
      mem_rd = 3'd7; mem_data = 16'h7777;
      tick();
      mem_valid = 1'b0; alu_valid = 1'b0;
      n_cmp++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL fill_5th_count: got %0d want 4", fifo_count); end
      n_cmp++; if (busy_mask !== 8'h66) begin n_err++; $display("FAIL fill_5th_busy: got %h want 66", busy_mask); end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if (rf_we !== 1'b1 || rf_rd !== rds[i] || rf_wd !== 16'h1000 + 16'(rds[i])) begin
            n_err++;
            $display("FAIL fill_drain%0d: got we=%b rd=%0d wd=%h want 1/%0d/%h", i, rf_we, rf_rd, rf_wd, rds[i], 16'h1000 + 16'(rds[i]));
         end
      end
      tick();
      n_cmp++; if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin n_err++; $display("FAIL fill_end: got we=%b count=%0d want 0/0", rf_we, fifo_count); end
   endtask

   task automatic test_starvation();
      alu_valid = 1'b1; alu_rd = 3'd4; alu_data = 16'h00A0;
      mem_valid = 1'b1; mem_rd = 3'd2; mem_data = 16'hBEEF;
      tick();
      mem_valid = 1'b0;
      n_cmp++; if (fifo_count !== 3'd1 || rf_wd !== 16'h00A0) begin n_err++; $display("FAIL starve_setup: got count=%0d wd=%h want 1/00a0", fifo_count, rf_wd); end
      for (int k = 1; k <= 4; k++) begin
         alu_data = 16'h00A0 + 16'(k);
         n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL starve_ready%0d: got %b want 1", k, alu_ready); end
         tick();
         n_cmp++; if (rf_we !== 1'b1 || rf_wd !== 16'h00A0 + 16'(k)) begin n_err++; $display("FAIL starve_alu%0d: got we=%b wd=%h want 1/%h", k, rf_we, rf_wd, 16'h00A0 + 16'(k)); end
      end
      alu_data = 16'h00A5;
      n_cmp++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL starve_force_ready: got %b want 0", alu_ready); end
      tick();
      n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 3'd2 || rf_wd !== 16'hBEEF) begin n_err++; $display("FAIL starve_pop: got we=%b rd=%0d wd=%h want 1/2/beef", rf_we, rf_rd, rf_wd); end
      n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL starve_ready_back: got %b want 1", alu_ready); end
      tick();
      alu_valid = 1'b0;
      n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 3'd4 || rf_wd !== 16'h00A5) begin n_err++; $display("FAIL starve_held_alu: got we=%b rd=%0d wd=%h want 1/4/00a5", rf_we, rf_rd, rf_wd); end
      tick();
   endtask

   task automatic test_simultaneous();
      alu_valid = 1'b1; alu_rd = 3'd4; alu_data = 16'h0001;
      mem_valid = 1'b1; mem_rd = 3'd7; mem_data = 16'h0002;
      tick();
      idle_inputs();
      n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 3'd4 || rf_wd !== 16'h0001) begin n_err++; $display("FAIL simul_alu: got we=%b rd=%0d wd=%h want 1/4/0001", rf_we, rf_rd, rf_wd); end
      n_cmp++; if (busy_mask !== 8'h80) begin n_err++; $display("FAIL simul_busy_t1: got %h want 80", busy_mask); end
      tick();
      n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 3'd7 || rf_wd !== 16'h0002) begin n_err++; $display("FAIL simul_load: got we=%b rd=%0d wd=%h want 1/7/0002", rf_we, rf_rd, rf_wd); end
      n_cmp++; if (busy_mask !== 8'h00) begin n_err++; $display("FAIL simul_busy_t2: got %h want 00", busy_mask); end
      tick();
   endtask

   task automatic test_bypass();
      alu_valid = 1'b0;
      mem_valid = 1'b1; mem_rd = 3'd1; mem_data = 16'hA5A5;
      tick();
      idle_inputs();
`ifdef WB_BYPASS_EN
      n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 3'd1 || rf_wd !== 16'hA5A5) begin n_err++; $display("FAIL bypass_t1: got we=%b rd=%0d wd=%h want 1/1/a5a5", rf_we, rf_rd, rf_wd); end
      n_cmp++; if (busy_mask !== 8'h00 || fifo_count !== 3'd0) begin n_err++; $display("FAIL bypass_nofifo: got busy=%h count=%0d want 00/0", busy_mask, fifo_count); end
      tick();
      n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL bypass_t2: got we=%b want 0", rf_we); end
`else
      n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL nobypass_t1: got we=%b want 0", rf_we); end
      n_cmp++; if (busy_mask !== 8'h02 || fifo_count !== 3'd1) begin n_err++; $display("FAIL nobypass_fifo: got busy=%h count=%0d want 02/1", busy_mask, fifo_count); end
      tick();
      n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 3'd1 || rf_wd !== 16'hA5A5) begin n_err++; $display("FAIL nobypass_t2: got we=%b rd=%0d wd=%h want 1/1/a5a5", rf_we, rf_rd, rf_wd); end
`endif
      tick();
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      tick();
      tick();
      reset = 1'b1;
      tick();
      test_reset();
      test_alu_path();
      test_fill();
      test_starvation();
      test_simultaneous();
      test_bypass();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
